// File: rtl/desafio4_fluxo_dados_if.sv
// desafio4_fluxo_dados_if: control/status bundle between the desafio4 control unit (master) and datapath (slave)
interface desafio4_fluxo_dados_if #(parameter int DATA_W = 4, parameter int ADDR_W = 4);
  logic [DATA_W-1:0] chaves;
  logic zeraC;
  logic contaC;
  logic zeraR;
  logic registraR;
  logic fimC;
  logic errou;
  logic jogada_feita;
  logic [ADDR_W-1:0] db_contagem;
  logic [DATA_W-1:0] db_jogada;
  logic [DATA_W-1:0] db_memoria;
  modport master(
    output chaves, zeraC, contaC, zeraR, registraR,
    input fimC, errou, jogada_feita, db_contagem, db_jogada, db_memoria
  );
  modport slave(
    input chaves, zeraC, contaC, zeraR, registraR,
    output fimC, errou, jogada_feita, db_contagem, db_jogada, db_memoria
  );
endinterface

// File: rtl/desafio4_fluxo_dados.sv
// desafio4_fluxo_dados: sequence counter, fixed ROM, move register, comparator and move-edge detector
module desafio4_fluxo_dados #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int LAST = 15
) (
  input logic clock,
  input logic reset,
  desafio4_fluxo_dados_if.slave dp
);
  logic [ADDR_W-1:0] contagem;
  logic [DATA_W-1:0] jogada;
  logic [DATA_W-1:0] memoria;
  logic [1:0] idx;
  logic a_prev;
  logic pulse;
  logic any_move;
  assign any_move = |dp.chaves;
  assign idx = 2'(contagem);
  assign memoria = DATA_W'(4'b0001 << idx);
  always_ff @(posedge clock) begin
    if (!reset) begin
      contagem <= '0;
      jogada <= '0;
      a_prev <= 1'b0;
      pulse <= 1'b0;
    end else begin
      a_prev <= any_move;
      pulse <= any_move & ~a_prev;
      if (dp.zeraC) contagem <= '0;
      else if (dp.contaC) contagem <= (contagem == ADDR_W'(LAST)) ? '0 : contagem + 1'b1;
      if (dp.zeraR) jogada <= '0;
      else if (dp.registraR) jogada <= dp.chaves;
    end
  end
  assign dp.fimC = contagem == ADDR_W'(LAST);
  assign dp.errou = jogada != memoria;
  assign dp.jogada_feita = pulse;
  assign dp.db_contagem = contagem;
  assign dp.db_jogada = jogada;
  assign dp.db_memoria = memoria;
endmodule

// File: tb/tb_desafio4_fluxo_dados.sv
// tb_desafio4_fluxo_dados: directed and random checks of the datapath against a behavioural model
module tb_desafio4_fluxo_dados;
  localparam int LAST = 15;
  logic clock = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  int m_cnt = 0;
  int m_jog = 0;
  bit m_prev = 1'b0;
  bit m_pulse = 1'b0;
  bit chk_en = 1'b0;
  int pulses;
  desafio4_fluxo_dados_if #(.DATA_W(4), .ADDR_W(4)) dp ();
  desafio4_fluxo_dados #(.DATA_W(4), .ADDR_W(4), .LAST(LAST)) dut (
    .clock(clock),
    .reset(reset),
    .dp(dp)
  );
  always #5 clock = ~clock;
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clock) begin
    if (!reset) begin
      m_cnt <= 0;
      m_jog <= 0;
      m_prev <= 1'b0;
      m_pulse <= 1'b0;
      chk_en <= 1'b1;
    end else begin
      m_prev <= dp.chaves != 0;
      m_pulse <= (dp.chaves != 0) && !m_prev;
      if (dp.zeraC) m_cnt <= 0;
      else if (dp.contaC) m_cnt <= (m_cnt == LAST) ? 0 : m_cnt + 1;
      if (dp.zeraR) m_jog <= 0;
      else if (dp.registraR) m_jog <= int'(dp.chaves);
    end
  end
  always @(negedge clock) begin
    if (chk_en) begin
      check("model_contagem", int'(dp.db_contagem), m_cnt);
      check("model_fimC", int'(dp.fimC), int'(m_cnt == LAST));
      check("model_memoria", int'(dp.db_memoria), 1 << (m_cnt % 4));
      check("model_jogada", int'(dp.db_jogada), m_jog);
      check("model_errou", int'(dp.errou), int'(m_jog != (1 << (m_cnt % 4))));
      check("model_jogada_feita", int'(dp.jogada_feita), int'(m_pulse));
    end
  end
  task automatic tick(input bit r, input int ch, input bit zc, input bit cc, input bit zr, input bit rr);
    reset = r;
    dp.chaves = 4'(ch);
    dp.zeraC = zc;
    dp.contaC = cc;
    dp.zeraR = zr;
    dp.registraR = rr;
    @(negedge clock);
    #1;
  endtask
  initial begin
    @(negedge clock);
    tick(0, 15, 0, 1, 0, 1);
    tick(0, 15, 0, 1, 0, 1);
    check("rst_contagem", int'(dp.db_contagem), 0);
    check("rst_jogada", int'(dp.db_jogada), 0);
    check("rst_jogada_feita", int'(dp.jogada_feita), 0);
    check("rst_fimC", int'(dp.fimC), 0);
    check("rst_errou", int'(dp.errou), 1);
    tick(1, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      tick(1, 0, 0, 1, 0, 0);
      check("count_value", int'(dp.db_contagem), i);
      check("count_fimC", int'(dp.fimC), int'(i == 15));
    end
    tick(1, 0, 0, 1, 0, 0);
    check("wrap_contagem", int'(dp.db_contagem), 0);
    check("wrap_fimC", int'(dp.fimC), 0);
    tick(1, 0, 1, 0, 0, 0);
    tick(1, 0, 0, 1, 0, 0);
    tick(1, 0, 0, 1, 0, 0);
    tick(1, 4, 0, 0, 0, 1);
    check("cmp_jogada", int'(dp.db_jogada), 4);
    check("cmp_memoria", int'(dp.db_memoria), 4);
    check("cmp_errou_match", int'(dp.errou), 0);
    tick(1, 2, 0, 0, 0, 1);
    check("cmp_errou_miss", int'(dp.errou), 1);
    tick(1, 8, 0, 0, 1, 1);
    check("zeraR_wins", int'(dp.db_jogada), 0);
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    check("edge_idle", int'(dp.jogada_feita), 0);
    pulses = 0;
    tick(1, 1, 0, 0, 0, 0);
    check("edge_pulse", int'(dp.jogada_feita), 1);
    pulses += int'(dp.jogada_feita);
    for (int i = 0; i < 2; i++) begin
      tick(1, 1, 0, 0, 0, 0);
      pulses += int'(dp.jogada_feita);
    end
    tick(1, 3, 0, 0, 0, 0);
    pulses += int'(dp.jogada_feita);
    tick(1, 3, 0, 0, 0, 0);
    pulses += int'(dp.jogada_feita);
    check("edge_pulse_count", pulses, 1);
    tick(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) tick(1, 0, 0, 1, 0, 0);
    check("pre_reset_count", int'(dp.db_contagem), 7);
    tick(0, 0, 0, 1, 0, 0);
    check("mid_reset_count", int'(dp.db_contagem), 0);
    tick(1, 0, 0, 1, 0, 0);
    check("resume_count", int'(dp.db_contagem), 1);
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(31) != 0,
           ($urandom_range(2) == 0) ? 0 : int'($urandom_range(15)),
           $urandom_range(7) == 0,
           $urandom_range(1) == 1,
           $urandom_range(5) == 0,
           $urandom_range(2) == 0);
    end
    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
